multi_crop_stream: RTL and testbench

//  Streaming multi-window crop for the image front end. Consumes one raster frame of IN_ROWS x IN_COLS

---
 rtl/multi_crop_stream_pkg.sv | 28 ++
 rtl/multi_crop_stream_if.sv | 34 +++
 rtl/multi_crop_stream_fifo.sv | 39 +++
 rtl/multi_crop_stream.sv | 168 ++++++++++++++++
 tb/tb_multi_crop_stream.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/multi_crop_stream_pkg.sv
// Shared types and default geometry for the multi-window crop stream.
package crop_pkg;

  // Default frame/window geometry
  localparam int DEF_PBW       = 8;
  localparam int DEF_CHANNELS  = 1;
  localparam int DEF_IN_ROWS   = 9;
  localparam int DEF_IN_COLS   = 9;
  localparam int DEF_NUM_CROPS = 2;

  localparam int YW  = $clog2(DEF_IN_ROWS);
  localparam int XW  = $clog2(DEF_IN_COLS);
  localparam int IDW = (DEF_NUM_CROPS > 1) ? $clog2(DEF_NUM_CROPS) : 1;

  // One output FIFO entry for the default geometry
  typedef struct packed {
    logic [DEF_CHANNELS*DEF_PBW-1:0] pixel;
    logic [IDW-1:0]                  id;
    logic                            last;
  } crop_entry_t;

  // Control FSM: accept input pixels, or expand one pixel into several crop hits
  typedef enum logic [0:0] {
    S_ACCEPT = 1'b0,
    S_EXPAND = 1'b1
  } crop_state_e;

endpackage

// File: rtl/multi_crop_stream_if.sv
// Stream bus for the crop block: input pixel stream, window config, tagged output stream.
// Handshake: a beat transfers on the rising clock edge where valid and ready are both high;
// valid must not wait for ready, and the payload is held stable while valid is high and ready is low.
interface multi_crop_stream_if #(
  parameter int PW        = 8,
  parameter int IDW       = 1,
  parameter int NUM_CROPS = 2,
  parameter int YW        = 4,
  parameter int XW        = 4
);
  logic [PW-1:0]           pixel_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CROPS*YW-1:0] cfg_y;
  logic [NUM_CROPS*XW-1:0] cfg_x;
  logic                    cfg_err;
  logic [PW-1:0]           pixel_out;
  logic [IDW-1:0]          out_crop_id;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  // Producer/consumer side (testbench or upstream/downstream logic)
  modport master (
    output pixel_in, in_valid, cfg_y, cfg_x, out_ready,
    input  in_ready, cfg_err, pixel_out, out_crop_id, out_last, out_valid
  );

  // Crop block side
  modport slave (
    input  pixel_in, in_valid, cfg_y, cfg_x, out_ready,
    output in_ready, cfg_err, pixel_out, out_crop_id, out_last, out_valid
  );
endinterface

// File: rtl/multi_crop_stream_fifo.sv
// Synchronous FIFO for crop output entries; pointers carry one extra wrap bit.
module crop_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer update; a full FIFO refuses pushes even if popped in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/multi_crop_stream.sv
// Streaming multi-window crop: tags every in-window pixel with its crop id and queues it.
module multi_crop_stream
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 8,
  parameter int CHANNELS        = 1,
  parameter int IN_ROWS         = 9,
  parameter int IN_COLS         = 9,
  parameter int OUT_ROWS        = 3,
  parameter int OUT_COLS        = 3,
  parameter int NUM_CROPS       = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                reset,
  multi_crop_stream_if.slave  bus,
  output crop_state_e         state_o
);
  localparam int PW   = CHANNELS * PIXEL_BIT_WIDTH;
  localparam int Y_W  = $clog2(IN_ROWS);
  localparam int X_W  = $clog2(IN_COLS);
  localparam int ID_W = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1;
  localparam int EW   = PW + ID_W + 1;

  crop_state_e                state_q, state_d;
  logic [Y_W-1:0]             row_q, row_d;
  logic [X_W-1:0]             col_q, col_d;
  logic [NUM_CROPS*Y_W-1:0]   cfg_y_q;
  logic [NUM_CROPS*X_W-1:0]   cfg_x_q;
  logic [NUM_CROPS-1:0]       en_q;
  logic                       cfg_err_q;
  logic [NUM_CROPS-1:0]       rem_q, rem_d;
  logic [NUM_CROPS-1:0]       lastm_q, lastm_d;
  logic [PW-1:0]              pix_q, pix_d;

  logic                       in_ready, accept, first;
  logic [NUM_CROPS*Y_W-1:0]   eff_y;
  logic [NUM_CROPS*X_W-1:0]   eff_x;
  logic [NUM_CROPS-1:0]       en_now, hit, last_hit, sel_mask, rest;
  logic [ID_W-1:0]            sel_id;
  logic                       push, pop, fifo_full, fifo_empty;
  logic [EW-1:0]              push_entry, head_entry;

  function automatic logic [ID_W-1:0] lowest_id(input logic [NUM_CROPS-1:0] m);
    lowest_id = '0;
    for (int k = NUM_CROPS - 1; k >= 0; k--) if (m[k]) lowest_id = ID_W'(k);
  endfunction

  assign in_ready = !reset && (state_q == S_ACCEPT) && !fifo_full;
  assign accept   = bus.in_valid && in_ready;
  assign first    = (row_q == '0) && (col_q == '0);
  // Pixel (0,0) already uses the config presented with it
  assign eff_y    = first ? bus.cfg_y : cfg_y_q;
  assign eff_x    = first ? bus.cfg_x : cfg_x_q;

  // Per-crop enable, window hit and last-pixel flags for the current raster position
  always_comb begin
    int ry, rx, lr, lc;
    ry = 0; rx = 0; lr = 0; lc = 0;
    en_now   = '0;
    hit      = '0;
    last_hit = '0;
    for (int k = 0; k < NUM_CROPS; k++) begin
      ry          = int'(eff_y[k*Y_W +: Y_W]);
      rx          = int'(eff_x[k*X_W +: X_W]);
      en_now[k]   = (ry + OUT_ROWS <= IN_ROWS) && (rx + OUT_COLS <= IN_COLS);
      lr          = int'(row_q) - ry;
      lc          = int'(col_q) - rx;
      hit[k]      = (first ? en_now[k] : en_q[k]) &&
                    (lr >= 0) && (lr < OUT_ROWS) && (lc >= 0) && (lc < OUT_COLS);
      last_hit[k] = (lr == OUT_ROWS - 1) && (lc == OUT_COLS - 1);
    end
  end

  assign sel_mask = (state_q == S_EXPAND) ? rem_q : hit;
  assign sel_id   = lowest_id(sel_mask);
  assign rest     = sel_mask & (sel_mask - NUM_CROPS'(1));

  // FSM, held-pixel registers and FIFO push selection
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    lastm_d    = lastm_q;
    pix_d      = pix_q;
    push       = 1'b0;
    push_entry = {bus.pixel_in, sel_id, last_hit[sel_id]};
    if (state_q == S_ACCEPT) begin
      push = accept && (|hit);
      if (accept && (|rest)) begin
        state_d = S_EXPAND;
        rem_d   = rest;
        lastm_d = last_hit;
        pix_d   = bus.pixel_in;
      end
    end else begin
      push       = !reset && !fifo_full;
      push_entry = {pix_q, sel_id, lastm_q[sel_id]};
      if (push) begin
        rem_d = rest;
        if (rest == '0) state_d = S_ACCEPT;
      end
    end
  end

  // Raster position of the next input pixel
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (col_q == X_W'(IN_COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == Y_W'(IN_ROWS - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State registers; config and enables are latched on the (0,0) accept only
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_ACCEPT;
      row_q     <= '0;
      col_q     <= '0;
      cfg_y_q   <= '0;
      cfg_x_q   <= '0;
      en_q      <= '0;
      cfg_err_q <= 1'b0;
      rem_q     <= '0;
      lastm_q   <= '0;
      pix_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rem_q     <= rem_d;
      lastm_q   <= lastm_d;
      pix_q     <= pix_d;
      cfg_err_q <= accept && first && (en_now != '1);
      if (accept && first) begin
        cfg_y_q <= bus.cfg_y;
        cfg_x_q <= bus.cfg_x;
        en_q    <= en_now;
      end
    end
  end

  assign pop = !reset && !fifo_empty && bus.out_ready;

  crop_stream_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.in_ready    = in_ready;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.out_valid   = !reset && !fifo_empty;
  assign bus.pixel_out   = reset ? '0 : head_entry[EW-1 -: PW];
  assign bus.out_crop_id = reset ? '0 : head_entry[ID_W:1];
  assign bus.out_last    = reset ? 1'b0 : head_entry[0];
  assign state_o         = state_q;
endmodule

// File: tb/tb_multi_crop_stream.sv
// Directed bench for multi_crop_stream: 9x9 frames, 3x3 windows, two crops, pixel = raster index.
module tb_multi_crop_stream;
  import crop_pkg::*;

  localparam int PW = 8;
  localparam int NC = 2;
  localparam int YWT = 4;
  localparam int XWT = 4;
  localparam int IDWT = 1;
  localparam int EW = PW + IDWT + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  crop_state_e dbg_state;
  multi_crop_stream_if #(.PW(PW), .IDW(IDWT), .NUM_CROPS(NC), .YW(YWT), .XW(XWT)) bus ();

  multi_crop_stream #(
    .PIXEL_BIT_WIDTH(8), .CHANNELS(1), .IN_ROWS(9), .IN_COLS(9),
    .OUT_ROWS(3), .OUT_COLS(3), .NUM_CROPS(NC), .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  bit sb_en = 1'b1;
  int err_cnt = 0;
  int out_mode = 0;          // 0: always ready, 1: random, 2: stalled
  int cy[NC], cx[NC];        // window origins currently driven
  int ny[NC], nx[NC];        // origins applied at a mid-frame change point

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int p, input int id, input bit last);
    return {8'(p), 1'(id), last};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_cfg();
    bus.cfg_y = {4'(cy[1]), 4'(cy[0])};
    bus.cfg_x = {4'(cx[1]), 4'(cx[0])};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_pixel_out", {bus.pixel_out, bus.out_crop_id, bus.out_last}, 0);
    check("post_rst_cfg_err", bus.cfg_err, 0);
    check("post_rst_state", dbg_state, S_ACCEPT);
  endtask

  // Offer pixels 0..stop_at-1; optionally switch cfg when pixel chg_at is offered
  task automatic send_frame(input bit rnd, input int stop_at, input int chg_at,
                            input int err_exp, output int ready_lows);
    int idx;
    int cyc;
    bit chk_err;
    idx = 0; cyc = 0; chk_err = 1'b0; ready_lows = 0;
    while (idx < stop_at && cyc < 3000) begin
      @(posedge clk); #1;
      bus.in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.pixel_in = 8'(idx);
      if (idx == chg_at) begin
        cy = ny; cx = nx;
        apply_cfg();
      end
      @(negedge clk);
      if (chk_err) begin
        check("cfg_err_pulse", bus.cfg_err, err_exp);
        chk_err = 1'b0;
      end
      if (!bus.in_ready) ready_lows++;
      if (bus.in_valid && bus.in_ready) begin
        if (idx == 0) chk_err = 1'b1;
        idx++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (idx < stop_at) check("frame_timeout", idx, stop_at);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    check("drain_out_valid", bus.out_valid, 0);
    check("drain_state", dbg_state, S_ACCEPT);
  endtask

  // Reference stream of one frame for the given window origins
  task automatic model_frame(input int y0, input int x0, input int y1, input int x1);
    int ys[NC];
    int xs[NC];
    ys[0] = y0; ys[1] = y1; xs[0] = x0; xs[1] = x1;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        for (int k = 0; k < NC; k++)
          if (ys[k] + 3 <= 9 && xs[k] + 3 <= 9 && r >= ys[k] && r < ys[k] + 3 &&
              c >= xs[k] && c < xs[k] + 3)
            exp_q.push_back(mk(r * 9 + c, k, (r - ys[k] == 2) && (c - xs[k] == 2)));
  endtask

  // ---------------- output side ----------------
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (out_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready && sb_en) begin
      if (exp_q.size() == 0) check("extra_output", 1, 0);
      else check("out_entry", {bus.pixel_out, bus.out_crop_id, bus.out_last}, exp_q.pop_front());
    end
    if (!reset && bus.cfg_err) err_cnt++;
  end

  // ---------------- directed vectors ----------------
  int s1_pix[9]  = '{20, 21, 22, 29, 30, 31, 38, 39, 40};
  int s2_pix[18] = '{20, 21, 22, 29, 30, 30, 31, 31, 32, 38, 39, 39, 40, 40, 41, 48, 49, 50};
  int s2_id[18]  = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    int lows;
    int lows3;
    bus.in_valid = 1'b0;
    bus.pixel_in = '0;
    cy = '{0, 0}; cx = '{0, 0};
    apply_cfg();
    do_reset();

    // Single active window (2,2); window 1 at (7,0) exceeds the frame
    cy = '{2, 7}; cx = '{2, 0};
    apply_cfg();
    err_cnt = 0;
    for (int i = 0; i < 9; i++) exp_q.push_back(mk(s1_pix[i], 0, i == 8));
    send_frame(1'b0, 81, -1, 1, lows);
    drain();
    check("s1_err_count", err_cnt, 1);

    // Overlapping windows (2,2) and (3,3)
    cy = '{2, 3}; cx = '{2, 3};
    apply_cfg();
    err_cnt = 0;
    for (int i = 0; i < 18; i++) exp_q.push_back(mk(s2_pix[i], s2_id[i], i == 12 || i == 17));
    send_frame(1'b0, 81, -1, 0, lows);
    drain();
    check("s2_ready_low_cycles", lows, 4);
    check("s2_err_count", err_cnt, 0);

    // Back-pressure: FIFO fills with 0,1,2,9 and input stalls
    cy = '{0, 6}; cx = '{0, 6};
    apply_cfg();
    model_frame(0, 0, 6, 6);
    out_mode = 2;
    fork
      send_frame(1'b0, 81, -1, 0, lows3);
      begin
        repeat (30) @(negedge clk);
        check("s3_in_ready_stalled", bus.in_ready, 0);
        check("s3_out_valid_held", bus.out_valid, 1);
        check("s3_head_entry", {bus.pixel_out, bus.out_crop_id, bus.out_last}, mk(0, 0, 0));
        check("s3_queue_untouched", exp_q.size(), 18);
        out_mode = 0;
      end
    join
    drain();

    // Random handshakes over three frames; cfg changed mid-frame 1
    out_mode = 1;
    cy = '{1, 4}; cx = '{5, 2};
    apply_cfg();
    ny = '{6, 0}; nx = '{0, 6};
    model_frame(1, 5, 4, 2);
    send_frame(1'b1, 81, 30, 0, lows);
    model_frame(6, 0, 0, 6);
    send_frame(1'b1, 81, -1, 0, lows);
    model_frame(6, 0, 0, 6);
    send_frame(1'b1, 81, -1, 0, lows);
    out_mode = 0;
    drain();

    // Reset after 40 inputs; following frame must match the single-window result
    sb_en = 1'b0;
    cy = '{2, 7}; cx = '{2, 0};
    apply_cfg();
    send_frame(1'b0, 40, -1, 1, lows);
    do_reset();
    exp_q.delete();
    sb_en = 1'b1;
    for (int i = 0; i < 9; i++) exp_q.push_back(mk(s1_pix[i], 0, i == 8));
    send_frame(1'b0, 81, -1, 1, lows);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
